// File: rtl/regfile_pkg.sv
// Shared defaults, types and helpers for the parametrised RV32I register file.
package regfile_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // True when v is a power of two no smaller than 2.
  function automatic bit is_pow2(int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read/write/reserve bus of the register file scoreboard.
interface regfile_scoreboard_if #(
  parameter int unsigned REGISTER_WIDTH_LENGTH = 32,
  parameter int unsigned NUM_REGISTERS         = 32,
  parameter int unsigned ADDRESS_WIDTH_LENGTH  = 5,
  parameter int unsigned NUM_READ_PORTS        = 2
);

  logic [NUM_READ_PORTS-1:0][ADDRESS_WIDTH_LENGTH-1:0]  ReadAddr;
  logic [NUM_READ_PORTS-1:0][REGISTER_WIDTH_LENGTH-1:0] ReadData;
  logic [NUM_READ_PORTS-1:0]                            ReadHazard;
  logic [ADDRESS_WIDTH_LENGTH-1:0]                      WriteReg;
  logic [REGISTER_WIDTH_LENGTH-1:0]                     WriteData;
  logic                                                 RegWrite;
  logic                                                 Reserve;
  logic [ADDRESS_WIDTH_LENGTH-1:0]                      ReserveReg;
  logic                                                 ReserveConflict;
  logic [NUM_REGISTERS-1:0]                             BusyVec;

  modport master (
    output ReadAddr, WriteReg, WriteData, RegWrite, Reserve, ReserveReg,
    input  ReadData, ReadHazard, ReserveConflict, BusyVec
  );

  modport slave (
    input  ReadAddr, WriteReg, WriteData, RegWrite, Reserve, ReserveReg,
    output ReadData, ReadHazard, ReserveConflict, BusyVec
  );

endinterface

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard with WAW conflict detection.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGISTERS        = 32,
  parameter int unsigned ADDRESS_WIDTH_LENGTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            reserve_i,
  input  logic [ADDRESS_WIDTH_LENGTH-1:0] reserve_reg_i,
  input  logic                            reg_write_i,
  input  logic [ADDRESS_WIDTH_LENGTH-1:0] write_reg_i,
  output logic [NUM_REGISTERS-1:0]        busy_o,
  output logic                            conflict_o
);

  logic [NUM_REGISTERS-1:0] busy_q, busy_d;
  logic                     conflict_q, conflict_d;
  logic                     rsv_valid, wr_valid;

  assign rsv_valid = reserve_i   && (reserve_reg_i != '0);
  assign wr_valid  = reg_write_i && (write_reg_i   != '0);

  // Next busy state: retire first, then reserve so a new producer wins on the same register.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[write_reg_i] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[reserve_reg_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    conflict_d = rsv_valid && busy_q[reserve_reg_i]
                 && !(reg_write_i && (write_reg_i == reserve_reg_i));
  end

  // Busy flops and conflict pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_o     = busy_q;
  assign conflict_o = conflict_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass, hardwired x0 and busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH_LENGTH = 32,
  parameter int unsigned NUM_REGISTERS         = 32,
  parameter int unsigned ADDRESS_WIDTH_LENGTH  = 5,
  parameter int unsigned NUM_READ_PORTS        = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);

  if (!is_pow2(NUM_REGISTERS) || (ADDRESS_WIDTH_LENGTH != $clog2(NUM_REGISTERS))
      || (NUM_READ_PORTS < 1) || (NUM_READ_PORTS > 4)) begin : g_bad_params
    $fatal(1, "regfile_scoreboard: illegal parameter combination");
  end

  logic [REGISTER_WIDTH_LENGTH-1:0]                     regs_q [NUM_REGISTERS];
  logic [NUM_READ_PORTS-1:0][REGISTER_WIDTH_LENGTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_READ_PORTS-1:0]                            rd_hz_q, rd_hz_d;
  logic [NUM_REGISTERS-1:0]                             busy;
  logic                                                 conflict;

  regfile_busy_tracker #(
    .NUM_REGISTERS        (NUM_REGISTERS),
    .ADDRESS_WIDTH_LENGTH (ADDRESS_WIDTH_LENGTH)
  ) u_busy (
    .clk           (clk),
    .rst_n         (rst_n),
    .reserve_i     (bus.Reserve),
    .reserve_reg_i (bus.ReserveReg),
    .reg_write_i   (bus.RegWrite),
    .write_reg_i   (bus.WriteReg),
    .busy_o        (busy),
    .conflict_o    (conflict)
  );

  // Storage array; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.RegWrite && (bus.WriteReg != '0)) begin
      regs_q[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Per-port read mux with same-cycle write bypass; a bypassed read is never a hazard.
  always_comb begin
    rd_data_d = '0;
    rd_hz_d   = '0;
    for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
      if (bus.ReadAddr[p] != '0) begin
        if (bus.RegWrite && (bus.WriteReg == bus.ReadAddr[p])) begin
          rd_data_d[p] = bus.WriteData;
        end else begin
          rd_data_d[p] = regs_q[bus.ReadAddr[p]];
          rd_hz_d[p]   = busy[bus.ReadAddr[p]];
        end
      end
    end
  end

  // Registered read data and hazard flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_hz_q   <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_hz_q   <= rd_hz_d;
    end
  end

  assign bus.ReadData        = rd_data_q;
  assign bus.ReadHazard      = rd_hz_q;
  assign bus.BusyVec         = busy;
  assign bus.ReserveConflict = conflict;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard (2 read ports, 32 x 32-bit).
module tb_regfile_scoreboard;

  logic clk;
  logic rst_n;

  int unsigned total;
  int unsigned bad;

  regfile_scoreboard_if #(
    .REGISTER_WIDTH_LENGTH (32),
    .NUM_REGISTERS         (32),
    .ADDRESS_WIDTH_LENGTH  (5),
    .NUM_READ_PORTS        (2)
  ) bus ();

  regfile_scoreboard #(
    .REGISTER_WIDTH_LENGTH (32),
    .NUM_REGISTERS         (32),
    .ADDRESS_WIDTH_LENGTH  (5),
    .NUM_READ_PORTS        (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  rr;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ehz;
    logic        ec;
    logic [31:0] ebusy;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [4:0] ra0, logic [4:0] ra1, logic we, logic [4:0] wr,
                              logic [31:0] wd, logic rsv, logic [4:0] rr, logic [31:0] e0,
                              logic [31:0] e1, logic [1:0] ehz, logic ec, logic [31:0] ebusy);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wr = wr; v.wd = wd; v.rsv = rsv; v.rr = rr;
    v.e0 = e0; v.e1 = e1; v.ehz = ehz; v.ec = ec; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd, input logic rsv,
                       input logic [4:0] rr);
    bus.ReadAddr[0] = ra0;
    bus.ReadAddr[1] = ra1;
    bus.RegWrite    = we;
    bus.WriteReg    = wr;
    bus.WriteData   = wd;
    bus.Reserve     = rsv;
    bus.ReserveReg  = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] ehz, input logic ec, input logic [31:0] ebusy);
    chk({tag, ".rd0"},  bus.ReadData[0], e0);
    chk({tag, ".rd1"},  bus.ReadData[1], e1);
    chk({tag, ".hz"},   {30'd0, bus.ReadHazard}, {30'd0, ehz});
    chk({tag, ".conf"}, {31'd0, bus.ReserveConflict}, {31'd0, ec});
    chk({tag, ".busy"}, bus.BusyVec, ebusy);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //            ra0 ra1 we wr  wd            rsv rr  e0            e1            hz     c     busy
    vecs[0]  = mk(0,  0,  1, 5,  32'hDEADBEEF, 0,  0,  32'h0,        32'h0,        2'b00, 1'b0, 32'h0);
    vecs[1]  = mk(5,  5,  0, 0,  32'h0,        0,  0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
    vecs[2]  = mk(0,  5,  1, 0,  32'h1234,     0,  0,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
    vecs[3]  = mk(0,  0,  0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        2'b00, 1'b0, 32'h0);
    vecs[4]  = mk(7,  7,  1, 7,  32'hA5A5A5A5, 0,  0,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0);
    vecs[5]  = mk(3,  7,  0, 0,  32'h0,        1,  3,  32'h0,        32'hA5A5A5A5, 2'b00, 1'b0, 32'h8);
    vecs[6]  = mk(3,  0,  0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        2'b01, 1'b0, 32'h8);
    vecs[7]  = mk(3,  3,  1, 3,  32'h42,       0,  0,  32'h42,       32'h42,       2'b00, 1'b0, 32'h0);
    vecs[8]  = mk(0,  0,  0, 0,  32'h0,        1,  9,  32'h0,        32'h0,        2'b00, 1'b0, 32'h200);
    vecs[9]  = mk(9,  1,  1, 9,  32'h99,       1,  9,  32'h99,       32'h0,        2'b00, 1'b0, 32'h200);
    vecs[10] = mk(9,  0,  0, 0,  32'h0,        0,  0,  32'h99,       32'h0,        2'b01, 1'b0, 32'h200);
    vecs[11] = mk(0,  0,  0, 0,  32'h0,        1,  4,  32'h0,        32'h0,        2'b00, 1'b0, 32'h210);
    vecs[12] = mk(0,  0,  0, 0,  32'h0,        1,  4,  32'h0,        32'h0,        2'b00, 1'b1, 32'h210);
    vecs[13] = mk(0,  0,  0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        2'b00, 1'b0, 32'h210);
    vecs[14] = mk(4,  4,  1, 4,  32'h4444,     0,  0,  32'h4444,     32'h4444,     2'b00, 1'b0, 32'h200);
    vecs[15] = mk(0,  0,  0, 0,  32'h0,        1,  0,  32'h0,        32'h0,        2'b00, 1'b0, 32'h200);
    vecs[16] = mk(5,  6,  1, 6,  32'h66,       1,  5,  32'hDEADBEEF, 32'h66,       2'b00, 1'b0, 32'h220);
    vecs[17] = mk(5,  9,  1, 9,  32'h999,      0,  0,  32'hDEADBEEF, 32'h999,      2'b01, 1'b0, 32'h20);
    vecs[18] = mk(6,  9,  1, 5,  32'h55,       0,  0,  32'h66,       32'h999,      2'b00, 1'b0, 32'h0);
    vecs[19] = mk(5,  7,  0, 0,  32'h0,        1,  2,  32'h55,       32'hA5A5A5A5, 2'b00, 1'b0, 32'h4);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    step();
    step();
    chk_all("reset0", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wr, vecs[i].wd,
            vecs[i].rsv, vecs[i].rr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].ehz,
              vecs[i].ec, vecs[i].ebusy);
    end

    // Build up a hazard and a conflict pulse, then reset between edges.
    drive(2, 0, 0, 0, 32'h0, 1, 2);
    step();
    chk_all("pre_rst", 32'h0, 32'h0, 2'b01, 1'b1, 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);

    drive(5, 7, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("post_rst", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);

    // Storage is usable immediately after reset release.
    drive(0, 0, 1, 5, 32'hCAFEF00D, 0, 0);
    step();
    drive(5, 0, 0, 0, 32'h0, 0, 0);
    step();
    chk("post_rst_rd", bus.ReadData[0], 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
